// File: rtl/rle_stream_ctrl.sv
// rle_stream_ctrl: run-length encoder for a signed sample stream.
// Consecutive equal samples become (value, count, last) pairs. Runs are
// split at MAX_RUN, and a frame's final run is closed on in_last.
// Optional build macro RLE_STREAM_CTRL_STATS_EN adds the pair_cnt and
// sample_cnt statistics outputs.
module rle_stream_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     in_last,
   input  logic                     sync_clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_value,
   output logic [CNT_W-1:0]         out_count,
   output logic                     out_last
`ifdef RLE_STREAM_CTRL_STATS_EN
   ,
   output logic [15:0]              pair_cnt,
   output logic [15:0]              sample_cnt
`endif
);

   localparam logic [CNT_W-1:0] MAX_RUN = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

   state_t                   state_q, state_d;
   logic signed [DATA_W-1:0] run_val_q, run_val_d;
   logic [CNT_W-1:0]         run_cnt_q, run_cnt_d;
   logic                     out_valid_q, out_valid_d;
   logic signed [DATA_W-1:0] out_value_q, out_value_d;
   logic [CNT_W-1:0]         out_count_q, out_count_d;
   logic                     out_last_q, out_last_d;
   logic                     slot_free;
   logic                     accept;
   logic                     emit;

   // The output register can take a new pair when it is empty or being drained.
   assign slot_free = !out_valid_q || out_ready;

   // Input back-pressure depends on state and on whether a pair can be emitted.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = 1'b1;
         ST_RUN:  in_ready = slot_free;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept = in_valid && in_ready;

   // Next-state logic: run accumulation, run closing, and pair emission.
   always_comb begin
      state_d     = state_q;
      run_val_d   = run_val_q;
      run_cnt_d   = run_cnt_q;
      out_valid_d = out_valid_q;
      out_value_d = out_value_q;
      out_count_d = out_count_q;
      out_last_d  = out_last_q;
      emit        = 1'b0;

      // A consumed pair leaves the register empty unless a new one is loaded.
      if (slot_free) begin
         out_valid_d = 1'b0;
      end

      if (sync_clr) begin
         state_d     = ST_IDLE;
         run_val_d   = '0;
         run_cnt_d   = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  run_val_d = in_data;
                  run_cnt_d = ONE;
                  if (!in_last) begin
                     state_d = ST_RUN;
                  end else if (slot_free) begin
                     // One-sample frame goes straight out.
                     emit        = 1'b1;
                     out_value_d = in_data;
                     out_count_d = ONE;
                     out_last_d  = 1'b1;
                  end else begin
                     // Previous frame's last pair still stalled downstream.
                     state_d = ST_FLUSH;
                  end
               end
            end
            ST_RUN: begin
               if (accept) begin
                  if ((in_data == run_val_q) && (run_cnt_q != MAX_RUN)) begin
                     run_cnt_d = run_cnt_q + ONE;
                     if (in_last) begin
                        emit        = 1'b1;
                        out_value_d = run_val_q;
                        out_count_d = run_cnt_q + ONE;
                        out_last_d  = 1'b1;
                        state_d     = ST_IDLE;
                     end
                  end else begin
                     // Value change or full counter closes the held run.
                     emit        = 1'b1;
                     out_value_d = run_val_q;
                     out_count_d = run_cnt_q;
                     out_last_d  = 1'b0;
                     run_val_d   = in_data;
                     run_cnt_d   = ONE;
                     if (in_last) begin
                        state_d = ST_FLUSH;
                     end
                  end
               end
            end
            ST_FLUSH: begin
               if (slot_free) begin
                  emit        = 1'b1;
                  out_value_d = run_val_q;
                  out_count_d = run_cnt_q;
                  out_last_d  = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
         if (emit) begin
            out_valid_d = 1'b1;
         end
      end
   end

   // State, held run, and output pair registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         run_val_q   <= '0;
         run_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_count_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_val_q   <= run_val_d;
         run_cnt_q   <= run_cnt_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_count_q <= out_count_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_value = out_value_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;

`ifdef RLE_STREAM_CTRL_STATS_EN
   logic [15:0] pair_cnt_q;
   logic [15:0] sample_cnt_q;

   // Saturating counters of emitted pairs and accepted samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_cnt_q   <= '0;
         sample_cnt_q <= '0;
      end else if (sync_clr) begin
         pair_cnt_q   <= '0;
         sample_cnt_q <= '0;
      end else begin
         if (emit && (pair_cnt_q != 16'hFFFF)) begin
            pair_cnt_q <= pair_cnt_q + 16'd1;
         end
         if (accept && (sample_cnt_q != 16'hFFFF)) begin
            sample_cnt_q <= sample_cnt_q + 16'd1;
         end
      end
   end

   assign pair_cnt   = pair_cnt_q;
   assign sample_cnt = sample_cnt_q;
`endif

endmodule

// File: tb/tb_rle_stream_ctrl.sv
// Testbench for rle_stream_ctrl: directed scenarios plus randomized frames,
// with expected pairs derived from the accepted sample list by a plain
// run-length model.
module tb_rle_stream_ctrl;

   localparam int DW = 8;
   localparam int CW = 8;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic signed [DW-1:0] in_data = '0;
   logic                 in_last = 1'b0;
   logic                 sync_clr = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic signed [DW-1:0] out_value;
   logic [CW-1:0]        out_count;
   logic                 out_last;
`ifdef RLE_STREAM_CTRL_STATS_EN
   logic [15:0]          pair_cnt;
   logic [15:0]          sample_cnt;
`endif

   typedef struct packed {
      logic signed [DW-1:0] v;
      logic [CW-1:0]        c;
      logic                 l;
   } pair_t;

   typedef struct packed {
      logic signed [DW-1:0] v;
      logic                 l;
   } smp_t;

   pair_t got_q[$];
   pair_t exp_q[$];
   smp_t  sent_q[$];
   int    checks = 0;
   int    failures = 0;

   rle_stream_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .sync_clr  (sync_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_value (out_value),
      .out_count (out_count),
      .out_last  (out_last)
`ifdef RLE_STREAM_CTRL_STATS_EN
      ,
      .pair_cnt  (pair_cnt),
      .sample_cnt(sample_cnt)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   // Record every pair that completes a handshake at the coming rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back({out_value, out_count, out_last});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain run-length coding of the accepted samples, runs capped at 2^CW-1.
   task automatic build_expected();
      logic signed [DW-1:0] cur;
      int                   cnt;
      cur = '0;
      cnt = 0;
      exp_q.delete();
      foreach (sent_q[i]) begin
         if (cnt > 0 && sent_q[i].v == cur && cnt < (2**CW - 1)) begin
            cnt++;
         end else begin
            if (cnt > 0) exp_q.push_back({cur, CW'(cnt), 1'b0});
            cur = sent_q[i].v;
            cnt = 1;
         end
         if (sent_q[i].l) begin
            exp_q.push_back({cur, CW'(cnt), 1'b1});
            cnt = 0;
         end
      end
   endtask

   task automatic send(input logic signed [DW-1:0] d, input logic l, input int pct);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int n = 0; n < 100 && !done; n++) begin
         out_ready = (int'($urandom_range(99)) < pct);
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("sample_accepted", 32'(done), 32'd1);
      if (done) sent_q.push_back({d, l});
   endtask

   task automatic drain_and_compare(input string tag, input int pct);
      build_expected();
      for (int n = 0; n < 2000 && got_q.size() < exp_q.size(); n++) begin
         out_ready = (int'($urandom_range(99)) < pct) || (n > 1000);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk({tag, " pair_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      foreach (exp_q[i]) begin
         if (i < got_q.size()) chk($sformatf("%s pair%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      sent_q.delete();
   endtask

   initial begin
      int                   len;
      int                   r;
      logic signed [DW-1:0] v;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_value", 32'(out_value), 32'd0);
      chk("rst out_count", 32'(out_count), 32'd0);
      chk("rst out_last",  32'(out_last),  32'd0);
      chk("rst in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single-sample frame from IDLE: pair one cycle after acceptance
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'sd9;
      in_last   = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      sent_q.push_back({8'sd9, 1'b1});
      @(negedge clk);
      chk("single out_valid", 32'(out_valid), 32'd1);
      chk("single out_value", 32'(out_value), 32'd9);
      chk("single out_count", 32'(out_count), 32'd1);
      chk("single out_last",  32'(out_last),  32'd1);
      drain_and_compare("single", 100);

      // 5,5,5,-3 with last on -3
      send(8'sd5, 1'b0, 100);
      send(8'sd5, 1'b0, 100);
      send(8'sd5, 1'b0, 100);
      send(-8'sd3, 1'b1, 100);
      drain_and_compare("run553", 100);

      // 300 identical samples split at the maximum run length
      for (int i = 0; i < 300; i++) send(8'sd7, (i == 299), 100);
      drain_and_compare("maxrun", 100);

      // Downstream stall right after the first pair
      send(8'sd1, 1'b0, 100);
      send(8'sd2, 1'b0, 100);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'sd3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall in_ready",  32'(in_ready),  32'd0);
         chk("stall out_valid", 32'(out_valid), 32'd1);
         chk("stall out_value", 32'(out_value), 32'd1);
         chk("stall out_count", 32'(out_count), 32'd1);
         chk("stall out_last",  32'(out_last),  32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      send(8'sd3, 1'b0, 100);
      send(8'sd4, 1'b1, 100);
      drain_and_compare("stall", 100);

      // Synchronous clear while a run of four 6s is held
      for (int i = 0; i < 4; i++) send(8'sd6, 1'b0, 100);
      sync_clr = 1'b1;
      @(posedge clk);
      #1;
      sync_clr = 1'b0;
      @(negedge clk);
      chk("clr out_valid", 32'(out_valid), 32'd0);
      chk("clr in_ready",  32'(in_ready),  32'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("clr no_pair", 32'(got_q.size()), 32'd0);
`ifdef RLE_STREAM_CTRL_STATS_EN
      chk("clr pair_cnt",   32'(pair_cnt),   32'd0);
      chk("clr sample_cnt", 32'(sample_cnt), 32'd0);
`endif
      sent_q.delete();
      got_q.delete();
      send(8'sd2, 1'b0, 100);
      send(8'sd2, 1'b1, 100);
      drain_and_compare("after_clr", 100);

      // Asynchronous reset mid-run with a pair pending downstream
      send(8'sd4, 1'b0, 100);
      send(8'sd4, 1'b0, 100);
      send(8'sd5, 1'b0, 100);
      out_ready = 1'b0;
      @(negedge clk);
      chk("pre_rst out_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst out_valid", 32'(out_valid), 32'd0);
      chk("arst out_value", 32'(out_value), 32'd0);
      chk("arst out_count", 32'(out_count), 32'd0);
      chk("arst out_last",  32'(out_last),  32'd0);
`ifdef RLE_STREAM_CTRL_STATS_EN
      chk("arst pair_cnt",   32'(pair_cnt),   32'd0);
      chk("arst sample_cnt", 32'(sample_cnt), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst no_pair",   32'(got_q.size()), 32'd0);
      chk("post_rst out_valid", 32'(out_valid),    32'd0);
      sent_q.delete();
      got_q.delete();

      // Randomized frames with random downstream back-pressure
      for (int f = 0; f < 8; f++) begin
         len = int'($urandom_range(1, 40));
         v   = '0;
         for (int i = 0; i < len; i++) begin
            if (i == 0 || $urandom_range(0, 2) == 0) begin
               r = int'($urandom_range(0, 3));
               v = DW'(r - 1);
            end
            send(v, (i == len - 1), 70);
         end
         drain_and_compare($sformatf("rand%0d", f), 70);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
